// File: rtl/cache_axi_line_master_pkg.sv
// Purpose : shared AXI4 encodings and the line-master FSM state type.
// Latency : n/a (types only).
// Backpressure: n/a.
package kuuga_axi_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_t;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_RD   = 3'd2,
        ST_AW   = 3'd3,
        ST_WR   = 3'd4,
        ST_BR   = 3'd5,
        ST_DONE = 3'd6
    } line_master_state_t;

endpackage

// File: rtl/cache_axi_line_master_if.sv
// Purpose : AXI4 AR/R/AW/W/B channel bundle between the line master and memory.
// Latency : n/a (wires only).
// Backpressure: plain AXI valid/ready on every channel.
// Modports: master (drives AR/AW/W valids and R/B readies), slave (the reverse).
interface cache_axi_line_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [3:0]          arid;
    logic                arvalid;
    logic                arready;

    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [3:0]          awid;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output araddr, arlen, arsize, arburst, arid, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready,
        output awaddr, awlen, awsize, awburst, awid, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arid, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready,
        input  awaddr, awlen, awsize, awburst, awid, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/cache_axi_line_master.sv
// Purpose : turns one cache miss request into one AXI4 burst (line refill or line write-back).
// Latency : zero-wait refill = 1 (AR) + LINE_WORDS + 1 cycles from acceptance to rsp_valid.
// Backpressure: one transaction in flight; req_ready only in IDLE; AR/AW/W hold until ready.
// Ports   : clk, rst_n (async active-low); req_* cache request; rsp_* one-cycle completion
//           with refill line; m_axi AXI4 master modport.
// Option  : define CACHE_AXI_LINE_MASTER_WRAP_EN for critical-word-first WRAP refills.
module cache_axi_line_master
    import kuuga_axi_pkg::*;
#(
    parameter int         ADDR_W     = 32,
    parameter int         DATA_W     = 32,
    parameter int         LINE_WORDS = 4,   // power of 2, 2..16
    parameter logic [3:0] AXI_ID     = 4'd0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [LINE_WORDS*DATA_W-1:0] req_line,
    output logic                         rsp_valid,
    output logic                         rsp_err,
    output logic [LINE_WORDS*DATA_W-1:0] rsp_line,
    cache_axi_line_master_if.master      m_axi
);

    localparam int WORD_BYTES = DATA_W / 8;
    localparam int LINE_BYTES = LINE_WORDS * WORD_BYTES;
    localparam int IDX_W      = $clog2(LINE_WORDS);
    localparam int WOFF_W     = $clog2(WORD_BYTES);
    localparam int LOFF_W     = $clog2(LINE_BYTES);

    localparam logic [7:0]        AXI_LEN   = 8'(LINE_WORDS - 1);
    localparam logic [2:0]        AXI_SIZE  = 3'(WOFF_W);
    localparam logic [IDX_W-1:0]  LAST_BEAT = IDX_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(LINE_BYTES - 1));
`ifdef CACHE_AXI_LINE_MASTER_WRAP_EN
    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(WORD_BYTES - 1));
`endif

    line_master_state_t                   state_q, state_d;
    logic [ADDR_W-1:0]                    addr_q, addr_d;
    logic [LINE_WORDS-1:0][DATA_W-1:0]    line_q, line_d;
    logic [LINE_WORDS-1:0][DATA_W-1:0]    rsp_line_q, rsp_line_d;
    logic                                 err_q, err_d;
    // beat_cnt_q is the word slot of the current beat; beat_num_q counts beats
    // so the final beat is found even when a WRAP refill starts mid-line.
    logic [IDX_W-1:0]                     beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]                     beat_num_q, beat_num_d;
    // Registered so it is low while reset is asserted and never follows req_valid.
    logic                                 req_ready_q, req_ready_d;

    // The write flag is carried by the AR vs AW branch of the FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        line_d      = line_q;
        rsp_line_d  = rsp_line_q;
        err_d       = err_q;
        beat_cnt_d  = beat_cnt_q;
        beat_num_d  = beat_num_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    err_d      = 1'b0;
                    line_d     = req_line;
                    beat_num_d = '0;
                    if (req_write) begin
                        addr_d     = req_addr & LINE_MASK;
                        beat_cnt_d = '0;
                        state_d    = ST_AW;
                    end else begin
`ifdef CACHE_AXI_LINE_MASTER_WRAP_EN
                        addr_d     = req_addr & WORD_MASK;
                        beat_cnt_d = req_addr[LOFF_W-1:WOFF_W];
`else
                        addr_d     = req_addr & LINE_MASK;
                        beat_cnt_d = '0;
`endif
                        state_d    = ST_AR;
                    end
                end
            end
            ST_AR: begin
                if (m_axi.arready) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (m_axi.rvalid) begin
                    rsp_line_d[beat_cnt_q] = m_axi.rdata;
                    if (m_axi.rresp != AXI_RESP_OKAY) begin
                        err_d = 1'b1;
                    end
                    beat_cnt_d = beat_cnt_q + IDX_W'(1);
                    beat_num_d = beat_num_q + IDX_W'(1);
                    // An early or missing RLAST ends the burst with an error.
                    if (beat_num_q == LAST_BEAT) begin
                        if (!m_axi.rlast) begin
                            err_d = 1'b1;
                        end
                        state_d = ST_DONE;
                    end else if (m_axi.rlast) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_AW: begin
                if (m_axi.awready) begin
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (m_axi.wready) begin
                    beat_cnt_d = beat_cnt_q + IDX_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = ST_BR;
                    end
                end
            end
            ST_BR: begin
                if (m_axi.bvalid) begin
                    err_d   = (m_axi.bresp != AXI_RESP_OKAY);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            line_q      <= '0;
            rsp_line_q  <= '0;
            err_q       <= 1'b0;
            beat_cnt_q  <= '0;
            beat_num_q  <= '0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            line_q      <= line_d;
            rsp_line_q  <= rsp_line_d;
            err_q       <= err_d;
            beat_cnt_q  <= beat_cnt_d;
            beat_num_q  <= beat_num_d;
            req_ready_q <= req_ready_d;
        end
    end

    // All channel controls decode the registered state only, so no ready
    // input can reach a valid output combinationally.
    assign req_ready = req_ready_q;

    assign m_axi.arvalid = (state_q == ST_AR);
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = AXI_LEN;
    assign m_axi.arsize  = AXI_SIZE;
`ifdef CACHE_AXI_LINE_MASTER_WRAP_EN
    assign m_axi.arburst = AXI_BURST_WRAP;
`else
    assign m_axi.arburst = AXI_BURST_INCR;
`endif
    assign m_axi.arid    = AXI_ID;
    assign m_axi.rready  = (state_q == ST_RD);

    assign m_axi.awvalid = (state_q == ST_AW);
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = AXI_LEN;
    assign m_axi.awsize  = AXI_SIZE;
    assign m_axi.awburst = AXI_BURST_INCR;
    assign m_axi.awid    = AXI_ID;

    assign m_axi.wvalid  = (state_q == ST_WR);
    assign m_axi.wdata   = line_q[beat_cnt_q];
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = (state_q == ST_WR) && (beat_cnt_q == LAST_BEAT);
    assign m_axi.bready  = (state_q == ST_BR);

    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_err   = (state_q == ST_DONE) && err_q;
    assign rsp_line  = rsp_line_q;

endmodule

// File: tb/tb_cache_axi_line_master.sv
module tb_cache_axi_line_master;
    import kuuga_axi_pkg::*;

    localparam logic [31:0] MEM_BASE = 32'h0010_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [127:0] req_line = '0;
    logic         rsp_valid;
    logic         rsp_err;
    logic [127:0] rsp_line;

    cache_axi_line_master_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    cache_axi_line_master #(.ADDR_W(32), .DATA_W(32), .LINE_WORDS(4), .AXI_ID(4'd0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_line  (req_line),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_line  (rsp_line),
        .m_axi     (axi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mem [64];

    // slave behaviour knobs
    bit stall_en = 1'b0;
    int err_beat = -1;
    int rst_beat = -1;

    // request table and results
    int           n_req;
    logic         req_w_t [2];
    logic [31:0]  req_a_t [2];
    logic [127:0] req_l_t [2];
    int           acc_cyc [2];
    int           rsp_cyc [2];
    logic [127:0] rsp_line_l [2];
    logic         rsp_err_l [2];
    int           n_acc, n_rsp;

    // channel logs
    logic [31:0] ar_addr_l, aw_addr_l;
    logic [7:0]  ar_len_l, aw_len_l;
    logic [2:0]  ar_size_l;
    logic [1:0]  ar_burst_l, aw_burst_l;
    logic [3:0]  ar_id_l;
    int stab_err, order_err, wlast_err;

    // slave state
    bit          r_active;
    int          r_beat;
    logic [31:0] r_addr;
    bit          aw_done;
    int          w_beat;
    logic [31:0] w_addr;
    bit          b_pend;
    bit          aw_wait, w_wait;
    logic [31:0] aw_addr_prev, wdata_prev;
    logic        wlast_prev;

    task automatic clear_slave();
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
        r_active = 0; r_beat = 0; aw_done = 0; w_beat = 0; b_pend = 0;
        aw_wait = 0; w_wait = 0;
        stab_err = 0; order_err = 0; wlast_err = 0;
    endtask

    // Cycle-by-cycle slave plus requester, stepping on falling edges.
    task automatic run(input int budget, output bit timed_out);
        int  idx;
        bit  adv;
        int  mi;
        logic [31:0] ra;
        idx = 0; adv = 0; n_acc = 0; n_rsp = 0; timed_out = 1;
        clear_slave();
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            cyc++;
            if (adv) begin idx++; adv = 0; end
            if (idx < n_req) begin
                req_valid = 1'b1; req_write = req_w_t[idx]; req_addr = req_a_t[idx]; req_line = req_l_t[idx];
            end else begin
                req_valid = 1'b0;
            end
            if (req_valid && req_ready) begin
                if (n_acc < 2) acc_cyc[n_acc] = cyc;
                n_acc++; adv = 1;
            end
            if (rsp_valid) begin
                if (n_rsp < 2) begin
                    rsp_cyc[n_rsp] = cyc; rsp_line_l[n_rsp] = rsp_line; rsp_err_l[n_rsp] = rsp_err;
                end
                n_rsp++;
            end
            // B channel
            axi.bvalid = b_pend; axi.bresp = 2'b00;
            if (b_pend && axi.bready) b_pend = 0;
            // W channel
            if (w_wait && (!axi.wvalid || axi.wdata !== wdata_prev || axi.wlast !== wlast_prev)) stab_err++;
            if (axi.wvalid) begin
                if (!aw_done) order_err++;
                axi.wready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                if (axi.wready) begin
                    if (axi.wlast !== (w_beat == 3)) wlast_err++;
                    mi = int'((w_addr - MEM_BASE) >> 2) + w_beat;
                    if (mi >= 0 && mi < 64) mem[mi] = axi.wdata;
                    w_beat++;
                    if (axi.wlast) begin b_pend = 1; aw_done = 0; end
                    w_wait = 0;
                end else begin
                    w_wait = 1; wdata_prev = axi.wdata; wlast_prev = axi.wlast;
                end
            end else begin
                axi.wready = 1'b0; w_wait = 0;
            end
            // AW channel
            if (aw_wait && (!axi.awvalid || axi.awaddr !== aw_addr_prev)) stab_err++;
            if (axi.awvalid) begin
                axi.awready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                if (axi.awready) begin
                    aw_addr_l = axi.awaddr; aw_len_l = axi.awlen; aw_burst_l = axi.awburst;
                    aw_done = 1; w_beat = 0; w_addr = axi.awaddr; aw_wait = 0;
                end else begin
                    aw_wait = 1; aw_addr_prev = axi.awaddr;
                end
            end else begin
                axi.awready = 1'b0; aw_wait = 0;
            end
            // R channel
            if (r_active) begin
                if (ar_burst_l == 2'b10)
                    ra = (r_addr & ~32'hF) + ((((r_addr >> 2) + 32'(r_beat)) & 32'h3) << 2);
                else
                    ra = r_addr + 32'(r_beat * 4);
                mi = int'((ra - MEM_BASE) >> 2);
                axi.rvalid = 1'b1;
                axi.rdata  = (mi >= 0 && mi < 64) ? mem[mi] : 32'hDEAD_BEEF;
                axi.rresp  = (r_beat == err_beat) ? 2'b10 : 2'b00;
                axi.rlast  = (r_beat == int'(ar_len_l));
                if (r_beat == rst_beat) begin
                    rst_n = 1'b0;
                    timed_out = 0;
                    return;
                end
                if (axi.rready) begin
                    r_beat++;
                    if (axi.rlast) r_active = 0;
                end
            end else begin
                axi.rvalid = 1'b0; axi.rlast = 1'b0;
            end
            // AR channel
            if (axi.arvalid) begin
                axi.arready = 1'b1;
                ar_addr_l = axi.araddr; ar_len_l = axi.arlen; ar_size_l = axi.arsize;
                ar_burst_l = axi.arburst; ar_id_l = axi.arid;
                r_active = 1; r_beat = 0; r_addr = axi.araddr;
            end else begin
                axi.arready = 1'b0;
            end
            if (n_rsp >= n_req) begin
                req_valid = 1'b0;
                timed_out = 0;
                return;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic single(input logic w, input logic [31:0] a, input logic [127:0] l, output bit to);
        n_req = 1; req_w_t[0] = w; req_a_t[0] = a; req_l_t[0] = l;
        run(200, to);
    endtask

    task automatic test_reset();
        clear_slave();
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %0b want 0", req_ready); end
        checks++; if ({axi.arvalid, axi.awvalid, axi.wvalid} !== 3'b000) begin errors++; $display("FAIL reset_valids got %b want 000", {axi.arvalid, axi.awvalid, axi.wvalid}); end
        checks++; if ({axi.rready, axi.bready} !== 2'b00) begin errors++; $display("FAIL reset_readies got %b want 00", {axi.rready, axi.bready}); end
        checks++; if ({rsp_valid, rsp_err} !== 2'b00 || rsp_line !== 128'h0) begin errors++; $display("FAIL reset_rsp got v=%0b e=%0b line=%h want 0", rsp_valid, rsp_err, rsp_line); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b want 1", req_ready); end
    endtask

    task automatic test_refill();
        bit to;
        single(1'b0, 32'h0010_0014, '0, to);
        checks++; if (to) begin errors++; $display("FAIL refill_timeout got timeout want rsp"); end
        checks++; if (ar_addr_l !== 32'h0010_0010) begin errors++; $display("FAIL refill_araddr got %h want 00100010", ar_addr_l); end
        checks++; if ({ar_len_l, ar_size_l, ar_burst_l, ar_id_l} !== {8'd3, 3'd2, 2'b01, 4'd0}) begin errors++; $display("FAIL refill_ar_fields got len=%0d size=%0d burst=%0d id=%0d want 3 2 1 0", ar_len_l, ar_size_l, ar_burst_l, ar_id_l); end
        checks++; if (rsp_line_l[0] !== {32'd7, 32'd6, 32'd5, 32'd4}) begin errors++; $display("FAIL refill_line got %h want 7_6_5_4", rsp_line_l[0]); end
        checks++; if (rsp_err_l[0] !== 1'b0) begin errors++; $display("FAIL refill_err got %0b want 0", rsp_err_l[0]); end
        checks++; if (rsp_cyc[0] - acc_cyc[0] != 6) begin errors++; $display("FAIL refill_latency got %0d want 6", rsp_cyc[0] - acc_cyc[0]); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL refill_pulse got %0b want 0", rsp_valid); end
    endtask

    task automatic test_wrap();
        bit to;
        single(1'b0, 32'h0010_0018, '0, to);
        checks++; if (to) begin errors++; $display("FAIL wrap_timeout got timeout want rsp"); end
`ifdef CACHE_AXI_LINE_MASTER_WRAP_EN
        checks++; if (ar_addr_l !== 32'h0010_0018 || ar_burst_l !== 2'b10) begin errors++; $display("FAIL wrap_ar got %h/%0d want 00100018/2", ar_addr_l, ar_burst_l); end
`else
        checks++; if (ar_addr_l !== 32'h0010_0010 || ar_burst_l !== 2'b01) begin errors++; $display("FAIL wrap_ar got %h/%0d want 00100010/1", ar_addr_l, ar_burst_l); end
`endif
        checks++; if (rsp_line_l[0] !== {32'd7, 32'd6, 32'd5, 32'd4}) begin errors++; $display("FAIL wrap_line got %h want 7_6_5_4", rsp_line_l[0]); end
        @(negedge clk);
    endtask

    task automatic test_writeback();
        bit to;
        stall_en = 1'b1;
        single(1'b1, 32'h0010_0020, {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}, to);
        stall_en = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL wb_timeout got timeout want rsp"); end
        checks++; if (aw_addr_l !== 32'h0010_0020 || aw_len_l !== 8'd3 || aw_burst_l !== 2'b01) begin errors++; $display("FAIL wb_aw got %h/%0d/%0d want 00100020/3/1", aw_addr_l, aw_len_l, aw_burst_l); end
        checks++; if ({mem[11], mem[10], mem[9], mem[8]} !== {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001}) begin errors++; $display("FAIL wb_mem got %h %h %h %h want aaaa0001..dddd0004", mem[8], mem[9], mem[10], mem[11]); end
        checks++; if (wlast_err != 0) begin errors++; $display("FAIL wb_wlast got %0d bad beats want 0", wlast_err); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL wb_stable got %0d changes want 0", stab_err); end
        checks++; if (order_err != 0) begin errors++; $display("FAIL wb_order got %0d early W want 0", order_err); end
        checks++; if (rsp_err_l[0] !== 1'b0) begin errors++; $display("FAIL wb_err got %0b want 0", rsp_err_l[0]); end
        @(negedge clk);
    endtask

    task automatic test_slverr();
        bit to;
        err_beat = 2;
        single(1'b0, 32'h0010_0000, '0, to);
        err_beat = -1;
        checks++; if (to) begin errors++; $display("FAIL slverr_timeout got timeout want rsp"); end
        checks++; if (r_beat != 4) begin errors++; $display("FAIL slverr_beats got %0d want 4", r_beat); end
        checks++; if (rsp_err_l[0] !== 1'b1) begin errors++; $display("FAIL slverr_err got %0b want 1", rsp_err_l[0]); end
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin errors++; $display("FAIL slverr_pulse got v=%0b e=%0b want 0 0", rsp_valid, rsp_err); end
        single(1'b0, 32'h0010_0010, '0, to);
        checks++; if (to || rsp_err_l[0] !== 1'b0 || rsp_line_l[0] !== {32'd7, 32'd6, 32'd5, 32'd4}) begin errors++; $display("FAIL slverr_next got to=%0b e=%0b line=%h want 0 0 7_6_5_4", to, rsp_err_l[0], rsp_line_l[0]); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit to;
        rst_beat = 1;
        single(1'b0, 32'h0010_0000, '0, to);
        rst_beat = -1;
        #1;
        checks++; if (rst_n !== 1'b0) begin errors++; $display("FAIL rstmid_reached got rst_n=%0b want 0", rst_n); end
        checks++; if ({axi.rready, axi.arvalid, rsp_valid} !== 3'b000) begin errors++; $display("FAIL rstmid_outputs got %b want 000", {axi.rready, axi.arvalid, rsp_valid}); end
        clear_slave();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %0b want 1", req_ready); end
        single(1'b0, 32'h0010_0000, '0, to);
        checks++; if (to || rsp_err_l[0] !== 1'b0 || rsp_line_l[0] !== {32'd3, 32'd2, 32'd1, 32'd0}) begin errors++; $display("FAIL rstmid_refill got to=%0b e=%0b line=%h want 0 0 3_2_1_0", to, rsp_err_l[0], rsp_line_l[0]); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit to;
        n_req = 2;
        req_w_t[0] = 1'b0; req_a_t[0] = 32'h0010_0010; req_l_t[0] = '0;
        req_w_t[1] = 1'b1; req_a_t[1] = 32'h0010_0040;
        req_l_t[1] = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'h1111_0001};
        run(300, to);
        checks++; if (to || n_rsp != 2) begin errors++; $display("FAIL b2b_count got to=%0b rsp=%0d want 0 2", to, n_rsp); end
        checks++; if (acc_cyc[1] - rsp_cyc[0] != 1) begin errors++; $display("FAIL b2b_gap got %0d want 1", acc_cyc[1] - rsp_cyc[0]); end
        checks++; if (rsp_line_l[0] !== {32'd7, 32'd6, 32'd5, 32'd4}) begin errors++; $display("FAIL b2b_line got %h want 7_6_5_4", rsp_line_l[0]); end
        checks++; if ({mem[19], mem[18], mem[17], mem[16]} !== req_l_t[1] || rsp_err_l[1] !== 1'b0) begin errors++; $display("FAIL b2b_wb got %h %h %h %h e=%0b want 11110001..44440004 0", mem[16], mem[17], mem[18], mem[19], rsp_err_l[1]); end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
        test_reset();
        test_refill();
        test_wrap();
        test_writeback();
        test_slverr();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
